// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between I-cache fills, D-cache fills and D-cache write-through
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W = 16,
  localparam int OW = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_fill_valid,
  output logic [15:0]       ic_fill_data,
  output logic [OW-1:0]     ic_fill_offset,
  output logic              ic_done,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wr_req,
  input  logic [15:0]       dc_wr_data,
  output logic              dc_fill_valid,
  output logic [15:0]       dc_fill_data,
  output logic [OW-1:0]     dc_fill_offset,
  output logic              dc_done,
  output logic              dc_wr_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_data_valid,
  output logic              busy,
  output logic [1:0]        owner
);
  typedef enum logic [1:0] {IDLE = 2'd0, IFILL = 2'd1, DFILL = 2'd2, DWRITE = 2'd3} state_t;
  state_t state, nextState;
  logic [OW:0] issueCnt;
  logic [OW-1:0] recvCnt;
  logic [ADDR_W-1:0] base;
  logic lastOwnerD;
  logic filling, issuing, rxValid, lastWord;
  // arbitration, fill progress and next state; write beats over a pending miss, fills alternate on contention
  always_comb begin
    filling = state == IFILL || state == DFILL;
    issuing = filling && !issueCnt[OW];
    rxValid = filling && mem_data_valid;
    lastWord = rxValid && recvCnt == OW'(BLOCK_WORDS - 1);
    nextState = state == IDLE ? (dc_wr_req ? DWRITE :
                                 (dc_miss && ic_miss) ? (lastOwnerD ? IFILL : DFILL) :
                                 dc_miss ? DFILL : ic_miss ? IFILL : IDLE) :
                (state == DWRITE || lastWord) ? IDLE : state;
  end
  // state, counters, block base and fairness bit; recvCnt wraps back to 0 on the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      issueCnt <= '0;
      recvCnt <= '0;
      base <= '0;
      lastOwnerD <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE) base <= (nextState == DFILL ? dc_addr : ic_addr) & ~ADDR_W'(2 * BLOCK_WORDS - 1);
      if (issuing) issueCnt <= issueCnt + 1'b1;
      if (rxValid) recvCnt <= recvCnt + 1'b1;
      if (lastWord) begin
        issueCnt <= '0;
        lastOwnerD <= state == DFILL;
      end
      if (state == DWRITE) lastOwnerD <= 1'b1;
    end
  end
  assign mem_en = issuing || state == DWRITE;
  assign mem_wr = state == DWRITE;
  assign mem_addr = issuing ? base | ADDR_W'({issueCnt[OW-1:0], 1'b0}) :
                    state == DWRITE ? {dc_addr[ADDR_W-1:1], 1'b0} : '0;
  assign mem_wdata = state == DWRITE ? dc_wr_data : '0;
  assign dc_wr_done = state == DWRITE;
  assign ic_fill_valid = rxValid && state == IFILL;
  assign ic_fill_data = ic_fill_valid ? mem_rdata : '0;
  assign ic_fill_offset = ic_fill_valid ? recvCnt : '0;
  assign ic_done = lastWord && state == IFILL;
  assign dc_fill_valid = rxValid && state == DFILL;
  assign dc_fill_data = dc_fill_valid ? mem_rdata : '0;
  assign dc_fill_offset = dc_fill_valid ? recvCnt : '0;
  assign dc_done = lastWord && state == DFILL;
  assign busy = state != IDLE;
  assign owner = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a 4-cycle latency memory model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_miss = 1'b0, dc_miss = 1'b0, dc_wr_req = 1'b0, spur = 1'b0;
  logic [15:0] ic_addr = '0, dc_addr = '0, dc_wr_data = '0;
  logic ic_fill_valid, ic_done, dc_fill_valid, dc_done, dc_wr_done, mem_en, mem_wr, busy;
  logic [15:0] ic_fill_data, dc_fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] ic_fill_offset, dc_fill_offset;
  logic [1:0] owner;
  logic mem_data_valid;
  logic [79:0] outs;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic [1:0] k;
    logic [15:0] a;
    logic [15:0] d;
    logic [3:0] off;
    logic done;
  } ev_t;
  ev_t fq[$];
  logic [15:0] rq[$];
  ev_t g, e;
  logic hasEv;

  mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_addr(ic_addr), .ic_fill_valid(ic_fill_valid), .ic_fill_data(ic_fill_data),
    .ic_fill_offset(ic_fill_offset), .ic_done(ic_done),
    .dc_miss(dc_miss), .dc_addr(dc_addr), .dc_wr_req(dc_wr_req), .dc_wr_data(dc_wr_data),
    .dc_fill_valid(dc_fill_valid), .dc_fill_data(dc_fill_data), .dc_fill_offset(dc_fill_offset),
    .dc_done(dc_done), .dc_wr_done(dc_wr_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  assign outs = {ic_fill_valid, ic_fill_data, ic_fill_offset, ic_done, dc_fill_valid, dc_fill_data,
                 dc_fill_offset, dc_done, dc_wr_done, mem_en, mem_wr, mem_addr, mem_wdata, busy, owner};

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // memory model: a read issued in cycle c returns data in cycle c+4
  logic [3:0] pv;
  logic [15:0] pa [4];
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv <= {pv[2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign mem_data_valid = pv[3] | spur;
  assign mem_rdata = pv[3] ? mdata(pa[3]) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_fill(input bit isD, input logic [15:0] addr);
    ev_t x;
    logic [15:0] b, a;
    b = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      a = b + 16'(2 * i);
      rq.push_back(a);
      x.k = isD ? 2'd2 : 2'd1;
      x.a = '0;
      x.d = mdata(a);
      x.off = 4'(i);
      x.done = i == 7;
      fq.push_back(x);
    end
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
    ev_t x;
    x.k = 2'd3;
    x.a = addr;
    x.d = data;
    x.off = '0;
    x.done = 1'b1;
    fq.push_back(x);
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = which == 0 ? ic_done : which == 1 ? dc_done : dc_wr_done;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_done(%0d): got timeout expected pulse within 200 cycles", which);
    end
    @(posedge clk);
    #1;
    if (which == 0) ic_miss = 0;
    else if (which == 1) dc_miss = 0;
    else dc_wr_req = 0;
  endtask

  // monitor: every fill word, memory write and memory read is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      hasEv = 1'b1;
      g = '0;
      if (ic_fill_valid && dc_fill_valid) begin
        miscompares++;
        $display("FAIL both_fill_valid: got 1 expected 0");
      end
      if (ic_fill_valid) begin
        g.k = 2'd1; g.d = ic_fill_data; g.off = 4'(ic_fill_offset); g.done = ic_done;
      end else if (dc_fill_valid) begin
        g.k = 2'd2; g.d = dc_fill_data; g.off = 4'(dc_fill_offset); g.done = dc_done;
      end else if (mem_en && mem_wr) begin
        g.k = 2'd3; g.a = mem_addr; g.d = mem_wdata; g.done = dc_wr_done;
      end else hasEv = 1'b0;
      if ((!ic_fill_valid && ic_done) || (!dc_fill_valid && dc_done) || (!(mem_en && mem_wr) && dc_wr_done)) begin
        miscompares++;
        $display("FAIL stray_done: got ic=%b dc=%b wr=%b expected 0", ic_done, dc_done, dc_wr_done);
      end
      if (hasEv) begin
        vectors++;
        if (fq.size() == 0) begin
          miscompares++;
          $display("FAIL sb_event: got k=%0d a=%h d=%h off=%0d done=%b expected no event", g.k, g.a, g.d, g.off, g.done);
        end else begin
          e = fq.pop_front();
          if (g !== e) begin
            miscompares++;
            $display("FAIL sb_event: got k=%0d a=%h d=%h off=%0d done=%b expected k=%0d a=%h d=%h off=%0d done=%b",
                     g.k, g.a, g.d, g.off, g.done, e.k, e.a, e.d, e.off, e.done);
          end
        end
      end
      if (mem_en && !mem_wr) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL sb_read: got addr %h expected no read", mem_addr);
        end else if (mem_addr !== rq[0]) begin
          miscompares++;
          $display("FAIL sb_read: got addr %h expected %h", mem_addr, rq.pop_front());
        end else void'(rq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs_zero", 32'(outs != 0), 0);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    // single I fill, exact cycle timing
    ic_addr = 16'h0036; ic_miss = 1; push_fill(0, 16'h0036);
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        chk("t1_mem_en", 32'(mem_en), 32'(k <= 8));
        if (k <= 8) chk("t1_mem_addr", 32'(mem_addr), 32'h30 + 32'(2 * (k - 1)));
        chk("t1_fill_valid", 32'(ic_fill_valid), 32'(k >= 5));
        if (k >= 5) chk("t1_offset", 32'(ic_fill_offset), 32'(k - 5));
        chk("t1_done", 32'(ic_done), 32'(k == 12));
      end
      if (k == 12) begin
        @(posedge clk);
        #1 ic_miss = 0;
      end
      if (k == 13) chk("t1_busy_c13", 32'(busy), 0);
    end
    // both pending, last owner I: D first
    dc_addr = 16'h4000; ic_addr = 16'h0200; dc_miss = 1; ic_miss = 1;
    push_fill(1, 16'h4000); push_fill(0, 16'h0200);
    @(posedge clk);
    @(negedge clk);
    chk("t2_owner_d", 32'(owner), 2);
    wait_done(1);
    wait_done(0);
    // write request during I fill waits for the fill to finish
    ic_addr = 16'h0350; ic_miss = 1; push_fill(0, 16'h0350);
    repeat (3) @(posedge clk);
    #1 dc_addr = 16'h0777; dc_wr_data = 16'h1357; dc_wr_req = 1; push_write(16'h0776, 16'h1357);
    wait_done(0);
    wait_done(2);
    repeat (5) @(posedge clk);
    #1;
    // both pending, last owner D: I first, I block wraps at top of memory
    ic_addr = 16'hFFFE; dc_addr = 16'h8888; ic_miss = 1; dc_miss = 1;
    push_fill(0, 16'hFFFE); push_fill(1, 16'h8888);
    @(posedge clk);
    @(negedge clk);
    chk("t4_owner_i", 32'(owner), 1);
    wait_done(0);
    wait_done(1);
    // write beats a simultaneous I miss
    dc_addr = 16'h1235; dc_wr_data = 16'hBEEF; dc_wr_req = 1; ic_addr = 16'h0A00; ic_miss = 1;
    push_write(16'h1234, 16'hBEEF); push_fill(0, 16'h0A00);
    @(posedge clk);
    @(negedge clk);
    chk("t5_mem_wr", 32'(mem_wr), 1);
    chk("t5_mem_addr", 32'(mem_addr), 32'h1234);
    chk("t5_wr_done", 32'(dc_wr_done), 1);
    @(posedge clk);
    #1 dc_wr_req = 0;
    @(negedge clk);
    chk("t5_busy_c2", 32'(busy), 0);
    @(negedge clk);
    chk("t5_owner_c3", 32'(owner), 1);
    wait_done(0);
    // reset in cycle 7 of a D fill, then restart from offset 0
    dc_addr = 16'h2468; dc_miss = 1; push_fill(1, 16'h2468);
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("t6_rst_outs_zero", 32'(outs != 0), 0);
    fq.delete();
    rq.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    push_fill(1, 16'h2468);
    wait_done(1);
    // spurious valid in IDLE, then I miss dropped right after grant
    spur = 1;
    @(negedge clk);
    chk("t7_spur_ic_fv", 32'(ic_fill_valid), 0);
    chk("t7_spur_dc_fv", 32'(dc_fill_valid), 0);
    @(posedge clk);
    #1 spur = 0;
    ic_addr = 16'h0ABC; ic_miss = 1; push_fill(0, 16'h0ABC);
    @(posedge clk);
    #1 ic_miss = 0;
    wait_done(0);
    repeat (10) @(posedge clk);
    chk("sb_empty", 32'(fq.size() + rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle unified main memory between the I-cache fill path and the D-cache fill/write-through path of the 16-bit CPU.
- Grants one requester at a time.
- For cache fills, issues a burst of BLOCK_WORDS sequential word reads and streams the returned words to the granted cache with a word offset.
- For D-cache store write-through, issues a single-word write.
- Sits between both caches and the memory model. The datapath stalls on the caches' miss signals, not on this block.

Parameters:
- BLOCK_WORDS, 8, words per cache block; power of two, range 2..16.
- ADDR_W, 16, byte address width. Memory words are 16 bits, so word addresses step by 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_miss  in  1  I-cache requests a block fill; held until ic_done.
- ic_addr  in  16  I-cache miss byte address.
- ic_fill_valid  out  1  ic_fill_data is valid this cycle.
- ic_fill_data  out  16  returned word.
- ic_fill_offset  out  log2(BLOCK_WORDS)  word index within the block.
- ic_done  out  1  one-cycle pulse with the last fill word.
- dc_miss  in  1  D-cache requests a block fill; held until dc_done.
- dc_addr  in  16  D-cache miss or write byte address.
- dc_wr_req  in  1  D-cache write-through request; held until dc_wr_done.
- dc_wr_data  in  16  store data.
- dc_fill_valid, dc_fill_data, dc_fill_offset, dc_done  out  same widths and meaning as the ic_* fill outputs.
- dc_wr_done  out  1  one-cycle pulse when the write is issued.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  access is a write (valid with mem_en).
- mem_addr  out  16  byte address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_data_valid  in  1  mem_rdata valid; read data returns in issue order, fixed latency ≥1 cycle.
- busy  out  1  state != IDLE.
- owner  out  2  0 none, 1 I-cache, 2 D-cache fill, 3 D-cache write.

Behaviour:
- Reset: async; state IDLE, counters 0, last_owner = I. All outputs 0.
- States: IDLE, IFILL, DFILL, DWRITE.
- IDLE arbitration, evaluated each cycle:
  - dc_wr_req has highest priority → DWRITE.
  - Otherwise, if dc_miss and ic_miss are both pending, grant the one that is not last_owner (alternating).
  - Otherwise grant whichever is pending.
  - Grant is registered: the state changes at the next edge. base = granted address with the low log2(BLOCK_WORDS)+1 bits cleared, captured at that edge.
- FILL states (IFILL/DFILL):
  - issue_cnt runs 0..BLOCK_WORDS-1, one read per cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - After the last issue, mem_en=0.
  - Each cycle with mem_data_valid: pass mem_rdata through combinationally to the owner's fill_data, assert fill_valid, set fill_offset = recv_cnt, then increment recv_cnt.
  - When recv_cnt == BLOCK_WORDS-1 and mem_data_valid: done pulses that cycle. Next state IDLE, last_owner = owner, counters cleared.
- DWRITE (one cycle): mem_en=1, mem_wr=1, mem_addr = dc_addr with bit 0 cleared, mem_wdata = dc_wr_data, dc_wr_done=1. Next state IDLE; last_owner = D.
- Latency for a fill, with request visible at edge 0 and memory latency L:
  - Issues in cycles 1..BLOCK_WORDS.
  - Words in cycles 1+L..BLOCK_WORDS+L; done in cycle BLOCK_WORDS+L.
  - Earliest new grant decision is in IDLE the following cycle.
- Boundary conditions:
  - Requester deasserts its miss mid-fill: the fill completes and done still pulses.
  - mem_data_valid while IDLE or DWRITE: ignored; no fill_valid.
  - The non-owner's fill_valid and done stay 0 at all times.
  - A new request arriving during a transaction waits; no preemption, including by dc_wr_req.
  - Reset mid-transaction: immediate abort, no done pulse; the requester re-requests.
  - Address wrap: base computed modulo 2^16; issue addresses never cross the block.

Test Plan:
- ic_miss, ic_addr=0x0036, memory latency L=4 → reads 0x0030..0x003E on cycles 1..8; ic_fill_valid cycles 5..12 with offsets 0..7; ic_done at cycle 12; busy 0 at cycle 13.
- dc_miss and ic_miss asserted in the same cycle after reset (last_owner=I) → DFILL first, then IFILL. Repeat with both pending again → IFILL precedes DFILL.
- dc_wr_req (addr 0x1235, data 0xBEEF) together with ic_miss → DWRITE first (mem_addr 0x1234, mem_wr=1, dc_wr_done one cycle), then IFILL starts 2 cycles after the request.
- dc_wr_req raised during an IFILL → no memory write until after ic_done; then exactly one write.
- rst asserted at cycle 7 of a DFILL → all outputs 0 immediately, no dc_done. After release with dc_miss still high, the fill restarts at offset 0.
- Spurious mem_data_valid in IDLE; ic_miss dropped after grant → no fill_valid in IDLE; the fill still delivers 8 words and ic_done.
